// File: rtl/watch_mode_ctrl.sv
// Button-driven mode sequencer for the watch chip.
// Edge-detects the buttons, runs the TIME / SET_H / SET_M / SW state machine,
// issues single-cycle command pulses to the time and stopwatch counters, and
// owns the backlight timer and the colon blink.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat of held inc/dec in the
// set states). With the macro undefined a held button yields one pulse only.
module watch_mode_ctrl #(
    parameter int unsigned LIGHT_SECS    = 3,
    parameter int unsigned REPEAT_DELAY  = 8,
    parameter int unsigned REPEAT_PERIOD = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_mode,
    input  logic       btn_set,
    input  logic       btn_inc,
    input  logic       btn_dec,
    input  logic       btn_light,
    input  logic       tick_1hz,
    output logic [1:0] mode,
    output logic       rtc_en,
    output logic       hour_inc,
    output logic       hour_dec,
    output logic       min_inc,
    output logic       min_dec,
    output logic       sec_clear,
    output logic       sw_run,
    output logic       sw_clear,
    output logic       disp_sel,
    output logic       colon,
    output logic       light
);

    localparam int unsigned LightW = $clog2(LIGHT_SECS + 1);

    typedef enum logic [1:0] {
        StTime = 2'd0,
        StSetH = 2'd1,
        StSetM = 2'd2,
        StSw   = 2'd3
    } state_e;

    state_e state_q, state_d;

    // Button vector order: {light, dec, inc, set, mode}
    logic [4:0] btn_now;
    logic [4:0] btn_q;
    logic [4:0] btn_edge;

    logic win_mode, win_set, win_inc, win_dec, light_edge;
    logic in_set;

    // Repeat pulses from the optional auto-repeat engine
    logic rpt_inc, rpt_dec;

    logic              hour_inc_q, hour_inc_d;
    logic              hour_dec_q, hour_dec_d;
    logic              min_inc_q, min_inc_d;
    logic              min_dec_q, min_dec_d;
    logic              sec_clear_q, sec_clear_d;
    logic              sw_run_q, sw_run_d;
    logic              sw_clear_q, sw_clear_d;
    logic              rtc_en_q, rtc_en_d;
    logic              disp_sel_q, disp_sel_d;
    logic              colon_q, colon_d;
    logic              light_q, light_d;
    logic [LightW-1:0] light_cnt_q, light_cnt_d;

    assign btn_now  = {btn_light, btn_dec, btn_inc, btn_set, btn_mode};
    assign btn_edge = btn_now & ~btn_q;

    // Fixed priority mode > set > inc > dec; light is independent
    assign win_mode   = btn_edge[0];
    assign win_set    = btn_edge[1] & ~btn_edge[0];
    assign win_inc    = btn_edge[2] & ~(|btn_edge[1:0]);
    assign win_dec    = btn_edge[3] & ~(|btn_edge[2:0]);
    assign light_edge = btn_edge[4];

    assign in_set = (state_q == StSetH) || (state_q == StSetM);

    // Button history register for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            btn_q <= 5'b0;
        end else begin
            btn_q <= btn_now;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StTime;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic driven by the winning edge
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StTime: begin
                if (win_mode) begin
                    state_d = StSw;
                end else if (win_set) begin
                    state_d = StSetH;
                end
            end
            StSetH: begin
                if (win_set) begin
                    state_d = StSetM;
                end
            end
            StSetM: begin
                if (win_set) begin
                    state_d = StTime;
                end
            end
            StSw: begin
                if (win_mode) begin
                    state_d = StTime;
                end
            end
            default: state_d = StTime;
        endcase
    end

`ifdef BTN_REPEAT_EN
    localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RptW   = $clog2(RptMax + 1);

    logic            rpt_act_q, rpt_act_d;
    logic            rpt_dec_q, rpt_dec_d;
    logic            rpt_first_q, rpt_first_d;
    logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
    logic [RptW-1:0] rpt_cnt_nx;
    logic            rpt_held;
    logic            rpt_fire;

    assign rpt_cnt_nx = rpt_cnt_q + 1'b1;
    assign rpt_held   = rpt_dec_q ? btn_dec : btn_inc;

    // Auto-repeat tracker: armed by an inc/dec edge, fires after the delay then every period
    always_comb begin
        rpt_act_d   = rpt_act_q;
        rpt_dec_d   = rpt_dec_q;
        rpt_first_d = rpt_first_q;
        rpt_cnt_d   = rpt_cnt_q;
        rpt_fire    = 1'b0;
        if (in_set && (win_inc || win_dec)) begin
            rpt_act_d   = 1'b1;
            rpt_dec_d   = win_dec;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = '0;
        end else if (!in_set || win_mode || win_set || !rpt_held || !rpt_act_q) begin
            rpt_act_d   = 1'b0;
            rpt_first_d = 1'b1;
            rpt_cnt_d   = '0;
        end else if (rpt_first_q && (rpt_cnt_nx == RptW'(REPEAT_DELAY))) begin
            rpt_fire    = 1'b1;
            rpt_first_d = 1'b0;
            rpt_cnt_d   = '0;
        end else if (!rpt_first_q && (rpt_cnt_nx == RptW'(REPEAT_PERIOD))) begin
            rpt_fire  = 1'b1;
            rpt_cnt_d = '0;
        end else begin
            rpt_cnt_d = rpt_cnt_nx;
        end
    end

    // Auto-repeat state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            rpt_act_q   <= 1'b0;
            rpt_dec_q   <= 1'b0;
            rpt_first_q <= 1'b1;
            rpt_cnt_q   <= '0;
        end else begin
            rpt_act_q   <= rpt_act_d;
            rpt_dec_q   <= rpt_dec_d;
            rpt_first_q <= rpt_first_d;
            rpt_cnt_q   <= rpt_cnt_d;
        end
    end

    assign rpt_inc = rpt_fire & ~rpt_dec_q;
    assign rpt_dec = rpt_fire & rpt_dec_q;
`else
    assign rpt_inc = 1'b0;
    assign rpt_dec = 1'b0;
`endif

    // Next values of all registered outputs
    always_comb begin
        hour_inc_d  = (state_q == StSetH) && (win_inc || rpt_inc);
        hour_dec_d  = (state_q == StSetH) && (win_dec || rpt_dec);
        min_inc_d   = (state_q == StSetM) && (win_inc || rpt_inc);
        min_dec_d   = (state_q == StSetM) && (win_dec || rpt_dec);
        sec_clear_d = (state_q == StSetM) && win_set;
        sw_clear_d  = (state_q == StSw) && win_dec && !sw_run_q;

        sw_run_d = sw_run_q;
        if ((state_q == StSw) && win_inc) begin
            sw_run_d = ~sw_run_q;
        end

        rtc_en_d   = (state_d == StTime) || (state_d == StSw);
        disp_sel_d = (state_d == StSw);

        // Colon blinks only while staying in TIME; entering TIME restarts it lit
        if ((state_d != StTime) || (state_q != StTime)) begin
            colon_d = 1'b1;
        end else if (tick_1hz) begin
            colon_d = ~colon_q;
        end else begin
            colon_d = colon_q;
        end

        // A press reloads even when a tick lands in the same cycle
        light_cnt_d = light_cnt_q;
        if (light_edge) begin
            light_cnt_d = LightW'(LIGHT_SECS);
        end else if (tick_1hz && (light_cnt_q != '0)) begin
            light_cnt_d = light_cnt_q - 1'b1;
        end
        light_d = (light_cnt_d != '0);
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            hour_inc_q  <= 1'b0;
            hour_dec_q  <= 1'b0;
            min_inc_q   <= 1'b0;
            min_dec_q   <= 1'b0;
            sec_clear_q <= 1'b0;
            sw_run_q    <= 1'b0;
            sw_clear_q  <= 1'b0;
            rtc_en_q    <= 1'b1;
            disp_sel_q  <= 1'b0;
            colon_q     <= 1'b1;
            light_q     <= 1'b0;
            light_cnt_q <= '0;
        end else begin
            hour_inc_q  <= hour_inc_d;
            hour_dec_q  <= hour_dec_d;
            min_inc_q   <= min_inc_d;
            min_dec_q   <= min_dec_d;
            sec_clear_q <= sec_clear_d;
            sw_run_q    <= sw_run_d;
            sw_clear_q  <= sw_clear_d;
            rtc_en_q    <= rtc_en_d;
            disp_sel_q  <= disp_sel_d;
            colon_q     <= colon_d;
            light_q     <= light_d;
            light_cnt_q <= light_cnt_d;
        end
    end

    assign mode      = state_q;
    assign rtc_en    = rtc_en_q;
    assign hour_inc  = hour_inc_q;
    assign hour_dec  = hour_dec_q;
    assign min_inc   = min_inc_q;
    assign min_dec   = min_dec_q;
    assign sec_clear = sec_clear_q;
    assign sw_run    = sw_run_q;
    assign sw_clear  = sw_clear_q;
    assign disp_sel  = disp_sel_q;
    assign colon     = colon_q;
    assign light     = light_q;

endmodule
